// File: rtl/mem_pkg.sv
// mem_pkg -- shared state encodings, wait-counter width and request error check
// for the data-memory responder.  Rev 1.0
`default_nettype none

package mem_pkg;

  localparam int WAIT_CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    RESP = ST_RESP
  } state_e;

  // Misaligned, beyond the word array, or no byte enabled.
  function automatic logic req_error(input logic [31:0] addr,
                                     input logic [3:0]  be,
                                     input int unsigned addr_width);
    logic [31:0] hi;
    hi = addr >> (addr_width + 2);
    return (addr[1:0] != 2'b00) || (hi != 32'd0) || (be == 4'b0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// dmem_array -- 2^ADDR_WIDTH x 32 word storage, per-byte write enable,
// registered read port.  Rev 1.0
`default_nettype none

module dmem_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            be,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // The read register only moves on a load, so it holds across a response.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// dmem_responder -- single-outstanding load/store responder with programmable
// wait states in front of dmem_array.  Rev 1.0
`default_nettype none

module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    write_q, write_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rd_ok_q, rd_ok_d;

  logic                    access;
  logic                    acc_write;
  logic [31:0]             acc_addr;
  logic [31:0]             acc_wdata;
  logic [3:0]              acc_be;
  logic                    acc_err;
  logic [31:0]             arr_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rsp_err_q  <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rsp_err_q  <= rsp_err_d;
      rd_ok_q    <= rd_ok_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rsp_err_d  = rsp_err_q;
    rd_ok_d    = rd_ok_q;
    access     = 1'b0;
    acc_write  = write_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    acc_be     = be_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          // With no wait states the access uses the live request on the accept edge.
          if (WAIT_CYCLES == 0) begin
            access    = 1'b1;
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
            state_d   = RESP;
          end else begin
            wait_cnt_d = WAIT_LOAD;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d   = IDLE;
          rsp_err_d = 1'b0;
          rd_ok_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    acc_err = req_error(acc_addr, acc_be, ADDR_WIDTH);
    if (access) begin
      rsp_err_d = acc_err;
      rd_ok_d   = !acc_write && !acc_err;
    end
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .en    (access && !acc_err && reset),
    .we    (acc_write),
    .addr  (acc_addr[ADDR_WIDTH+1:2]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (arr_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rd_ok_q ? arr_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- directed bench over three responders with WAIT_CYCLES
// of 2, 3 and 0.  Rev 1.0
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .reset(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_be(req_be[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input int d, input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready[d]), 32'd1);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata[d], 32'd0);
    chk({tag, ".rsp_err"},   32'(rsp_err[d]), 32'd0);
  endtask

  // Called #1 after an edge; returns #1 after the response handshake edge.
  task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input int exp_lat,
                     input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int lat;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    req_be[d]    = be;
    rsp_ready[d] = 1'b1;
    req_valid[d] = 1'b1;
    chk({tag, ".req_ready"}, 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 0;
    while (!rsp_valid[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".rsp_err"}, 32'(rsp_err[d]), 32'(exp_err));
    chk({tag, ".rsp_rdata"}, rsp_rdata[d], exp_rd);
    @(posedge clk); #1;
    chk({tag, ".rsp_done"}, 32'(rsp_valid[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      req_be[d]    = 4'h0;
      rsp_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals(0, "rst_w2");
    chk_reset_vals(2, "rst_w0");
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

    // Basic store/load, byte-enable merge.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2, 1'b0, 32'h0, "st_full");
    txn(0, 1'b0, 32'h10, 32'h0,        4'hF, 2, 1'b0, 32'hDEADBEEF, "ld_full");
    txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 2, 1'b0, 32'h0, "st_byte0");
    txn(0, 1'b0, 32'h10, 32'h0,        4'hF, 2, 1'b0, 32'hDEADBEAA, "ld_merged");
    txn(0, 1'b1, 32'h0,  32'h00000055, 4'hF, 2, 1'b0, 32'h0, "st_word0");

    // Errors leave the array untouched; 0x400 would alias to word 0.
    txn(0, 1'b0, 32'h13,  32'h0,        4'hF, 2, 1'b1, 32'h0, "err_misalign");
    txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 2, 1'b1, 32'h0, "err_range");
    txn(0, 1'b1, 32'h10,  32'h11111111, 4'h0, 2, 1'b1, 32'h0, "err_be0");
    txn(0, 1'b0, 32'h10,  32'h0,        4'hF, 2, 1'b0, 32'hDEADBEAA, "ld_after_err");
    txn(0, 1'b0, 32'h0,   32'h0,        4'hF, 2, 1'b0, 32'h00000055, "ld_word0");

    // Response backpressure with a second request waiting.
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h10;
    req_be[0]    = 4'hF;
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_addr[0] = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp.rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp.rsp_rdata", rsp_rdata[0], 32'hDEADBEAA);
      chk("bp.rsp_err",   32'(rsp_err[0]), 32'd0);
      chk("bp.req_ready", 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp.hs_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp.hs_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    chk("bp.accepted", 32'(req_ready[0]), 32'd0);
    req_valid[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("bp.next_valid", 32'(rsp_valid[0]), 32'd1);
    chk("bp.next_rdata", rsp_rdata[0], 32'h00000055);
    @(posedge clk); #1;

    // Reset during WAIT drops the pending store.
    txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 3, 1'b0, 32'h0, "w3_st");
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h20;
    req_wdata[1] = 32'h12345678;
    req_be[1]    = 4'hF;
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    chk_reset_vals(1, "rst_wait");
    repeat (4) @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    txn(1, 1'b0, 32'h20, 32'h0, 4'hF, 3, 1'b0, 32'hCAFEF00D, "w3_ld_prior");

    // Reset during RESP discards the response.
    req_write[1] = 1'b0;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rresp.valid", 32'(rsp_valid[1]), 32'd1);
    rst_n[1] = 1'b0;
    #1;
    chk_reset_vals(1, "rst_resp");
    @(posedge clk); #1;
    rst_n[1] = 1'b1;

    // Zero wait states: back-to-back loads every two cycles.
    txn(2, 1'b1, 32'h4, 32'h0A0B0C0D, 4'hF, 0, 1'b0, 32'h0, "w0_st4");
    txn(2, 1'b1, 32'h8, 32'h11223344, 4'hF, 0, 1'b0, 32'h0, "w0_st8");
    req_write[2] = 1'b0;
    req_addr[2]  = 32'h4;
    req_be[2]    = 4'hF;
    rsp_ready[2] = 1'b1;
    req_valid[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("b2b.rsp_valid", 32'(rsp_valid[2]), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("b2b.req_ready", 32'(req_ready[2]), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 0) begin
        chk("b2b.rsp_rdata", rsp_rdata[2], (k == 2) ? 32'h11223344 : 32'h0A0B0C0D);
      end else begin
        req_addr[2] = (k == 1) ? 32'h8 : 32'h4;
      end
      if (k == 5) req_valid[2] = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b.idle", 32'(req_ready[2]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
